// File: rtl/reg_wb_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_sequencer_pkg
// Description : Shared definitions for the register-file writeback sequencer:
//               register index constants, FSM state encoding and the
//               buffered writeback entry.
// Contents    : WB_DATA_W / WB_IDX_W - widths of a buffered entry
//               REG_ZERO, REG_SP, MAX_IDX - register file landmarks
//               ST_* - sequencer state encoding (ST_W bits)
//               wb_entry_t - {dest, data}
//               idx_writable() - true for indices that reach storage
// Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_sequencer_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_IDX_W  = 5;

  localparam logic [WB_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [WB_IDX_W-1:0] REG_SP   = 5'd17;
  localparam int                  MAX_IDX  = 17;

  localparam int            ST_W      = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_SETUP  = 2'd1;
  localparam logic [ST_W-1:0] ST_STROBE = 2'd2;
  localparam logic [ST_W-1:0] ST_HOLD   = 2'd3;

  typedef struct packed {
    logic [WB_IDX_W-1:0]  dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // r0 is hard-wired zero and anything past max_idx has no storage behind it.
  function automatic logic idx_writable(input logic [WB_IDX_W-1:0] idx,
                                        input int                  max_idx);
    return (idx != REG_ZERO) && (int'(idx) <= max_idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_wb_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_sequencer_if
// Description : Bundle of the writeback request channels, the register-file
//               write port and the status outputs of the sequencer.
// Ports       : alu_* / mem_*  - two valid/ready writeback request channels
//               reg_dest_out, data_out, reg_wen_out - register file write port
//               pend_sel_in / pend_hit_out - pending-write query
//               drop_cnt_out, idle_out - status
//               modport slave  : the sequencer side
//               modport master : the requester / register-file side
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_wb_sequencer_if
  import reg_wb_sequencer_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int IDX_W  = WB_IDX_W
);
  logic              alu_valid_in;
  logic              alu_ready_out;
  logic [IDX_W-1:0]  alu_dest_in;
  logic [DATA_W-1:0] alu_data_in;
  logic              mem_valid_in;
  logic              mem_ready_out;
  logic [IDX_W-1:0]  mem_dest_in;
  logic [DATA_W-1:0] mem_data_in;
  logic [IDX_W-1:0]  reg_dest_out;
  logic [DATA_W-1:0] data_out;
  logic              reg_wen_out;
  logic [IDX_W-1:0]  pend_sel_in;
  logic              pend_hit_out;
  logic [7:0]        drop_cnt_out;
  logic              idle_out;

  modport slave (
    input  alu_valid_in, alu_dest_in, alu_data_in,
    input  mem_valid_in, mem_dest_in, mem_data_in,
    input  pend_sel_in,
    output alu_ready_out, mem_ready_out,
    output reg_dest_out, data_out, reg_wen_out,
    output pend_hit_out, drop_cnt_out, idle_out
  );

  modport master (
    output alu_valid_in, alu_dest_in, alu_data_in,
    output mem_valid_in, mem_dest_in, mem_data_in,
    output pend_sel_in,
    input  alu_ready_out, mem_ready_out,
    input  reg_dest_out, data_out, reg_wen_out,
    input  pend_hit_out, drop_cnt_out, idle_out
  );
endinterface
`default_nettype wire

// File: rtl/reg_wb_sequencer_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous in-order FIFO of writeback entries with async
//               reset. Besides the head it exposes, per storage slot, whether
//               the slot holds a live entry and its destination index, so the
//               owner can search all queued destinations in parallel.
// Ports       : clk, rst          - clock, async active-high reset
//               push, push_entry  - enqueue (caller guarantees !full)
//               pop, head         - dequeue / current head (valid if !empty)
//               full, empty, count
//               ent_valid[DEPTH]  - slot holds a queued entry
//               ent_dest          - flattened slot destination indices
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import reg_wb_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire                         clk,
  input  wire                         rst,
  input  wire                         push,
  input  wb_entry_t                   push_entry,
  input  wire                         pop,
  output wb_entry_t                   head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH*WB_IDX_W-1:0]   ent_dest
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_PTR_ONE = 1;
  localparam logic [PTR_W:0] C_DEPTH   = DEPTH[PTR_W:0];

  // One extra pointer bit separates the full and empty cases.
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  wb_entry_t      r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_entry;
  end

  assign head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (count == C_DEPTH);

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] w_ofs;
    assign w_ofs        = PTR_W'(i) - r_rd_ptr[PTR_W-1:0];
    assign ent_valid[i] = ({1'b0, w_ofs} < count);
    assign ent_dest[i*WB_IDX_W +: WB_IDX_W] = r_mem[i].dest;
  end

endmodule
`default_nettype wire

// File: rtl/reg_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_sequencer
// Description : Write-side front end of the 18-entry register file. Arbitrates
//               ALU (priority) and load-path writeback requests into a FIFO,
//               then replays each entry on the single write port as
//               SETUP -> STROBE -> HOLD so dest/data are stable around a
//               one-cycle registered enable.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - reg_wb_sequencer_if.slave (request channels, write
//                      port, pending-write query, drop count, idle)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_sequencer
  import reg_wb_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_IDX = reg_wb_sequencer_pkg::MAX_IDX,
  // Must match the package entry widths; the FIFO stores wb_entry_t.
  parameter int DATA_W  = WB_DATA_W,
  parameter int IDX_W   = WB_IDX_W
) (
  input wire                  clk,
  input wire                  rst,
  reg_wb_sequencer_if.slave   bus
);

  logic [ST_W-1:0]            r_state;
  logic [ST_W-1:0]            w_state_nxt;

  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(DEPTH):0]     w_count;
  logic [DEPTH-1:0]           w_ent_valid;
  logic [DEPTH*WB_IDX_W-1:0]  w_ent_dest;
  wb_entry_t                  w_head;
  wb_entry_t                  w_push_entry;

  logic                       w_alu_take;
  logic                       w_mem_take;
  logic                       w_take;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_pop;
  logic                       w_wen_nxt;
  logic [IDX_W-1:0]           w_req_dest;
  logic [DATA_W-1:0]          w_req_data;

  logic [IDX_W-1:0]           r_dest;
  logic [DATA_W-1:0]          r_data;
  logic                       r_wen;
  logic [7:0]                 r_drop_cnt;

  logic                       w_q_hit;
  logic                       w_fly_hit;

  // ---------------------------------------------------------------- arbitration
  // Full comes from the registered count, so a same-cycle pop never frees a
  // slot early. ALU wins; the load path only sees ready when ALU is quiet.
  assign bus.alu_ready_out = !w_full;
  assign bus.mem_ready_out = !w_full && !bus.alu_valid_in;

  assign w_alu_take = bus.alu_valid_in && !w_full;
  assign w_mem_take = bus.mem_valid_in && !w_full && !bus.alu_valid_in;
  assign w_take     = w_alu_take || w_mem_take;
  assign w_req_dest = w_alu_take ? bus.alu_dest_in : bus.mem_dest_in;
  assign w_req_data = w_alu_take ? bus.alu_data_in : bus.mem_data_in;

  // Accepted requests to r0 or out-of-range indices are swallowed and counted.
  assign w_push       = w_take && idx_writable(w_req_dest, MAX_IDX);
  assign w_drop       = w_take && !w_push;
  assign w_push_entry = '{dest: w_req_dest, data: w_req_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // ----------------------------------------------------------------------- FIFO
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count),
    .ent_valid  (w_ent_valid),
    .ent_dest   (w_ent_dest)
  );

  // ------------------------------------------------------------------------ FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!w_empty) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_STROBE;
      ST_STROBE: w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = w_empty ? ST_IDLE : ST_SETUP;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Pop happens on the transition into SETUP; the enable is pre-decoded from
  // SETUP so the flop output is high exactly while the state is STROBE.
  always_comb begin
    w_pop     = 1'b0;
    w_wen_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_HOLD: w_pop     = !w_empty;
      ST_SETUP:         w_wen_nxt = 1'b1;
      default:          ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
    end else begin
      r_wen <= w_wen_nxt;
      if (w_pop) begin
        r_dest <= w_head.dest;
        r_data <= w_head.data;
      end
    end
  end

  assign bus.reg_wen_out  = r_wen;
  assign bus.reg_dest_out = r_dest;
  assign bus.data_out     = r_data;
  assign bus.drop_cnt_out = r_drop_cnt;
  assign bus.idle_out     = (r_state == ST_IDLE) && (w_count == '0);

  // -------------------------------------------------------------- pending query
  // A write stays pending while queued or being set up / strobed; once in
  // HOLD the storage has captured it.
  always_comb begin
    w_q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && (w_ent_dest[i*WB_IDX_W +: WB_IDX_W] == bus.pend_sel_in))
        w_q_hit = 1'b1;
    end
  end

  assign w_fly_hit = ((r_state == ST_SETUP) || (r_state == ST_STROBE)) &&
                     (r_dest == bus.pend_sel_in);
  assign bus.pend_hit_out = (bus.pend_sel_in != '0) && (w_q_hit || w_fly_hit);

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_sequencer
// Description : Self-checking bench for reg_wb_sequencer. Directed scenarios
//               for timing, arbitration, drops, back-pressure, pending query
//               and mid-strobe reset, plus a randomized run against an
//               in-order write list / drop counter / pending-set model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_wb_sequencer_if #(.DATA_W(32), .IDX_W(5)) bus ();

  reg_wb_sequencer #(.DEPTH(4), .MAX_IDX(17), .DATA_W(32), .IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observed register-file writes, recorded at each falling edge.
  int unsigned cyc = 0;
  logic [4:0]  obs_dest[$];
  logic [31:0] obs_data[$];
  int unsigned obs_cyc[$];
  int          wen_double = 0;
  logic        prev_wen = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.reg_wen_out === 1'b1) begin
      obs_dest.push_back(bus.reg_dest_out);
      obs_data.push_back(bus.data_out);
      obs_cyc.push_back(cyc);
      if (prev_wen === 1'b1) wen_double++;
    end
    prev_wen = bus.reg_wen_out;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Every phase of the bench starts 1 time unit after a falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.alu_valid_in = 1'b0; bus.alu_dest_in = '0; bus.alu_data_in = '0;
    bus.mem_valid_in = 1'b0; bus.mem_dest_in = '0; bus.mem_data_in = '0;
    bus.pend_sel_in  = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Offer one ALU request and hold it until accepted; returns the number of
  // cycles ready was low. Returns one phase after the accepting edge.
  task automatic alu_push(input logic [4:0] d, input logic [31:0] v, output int stalls);
    stalls = 0;
    bus.alu_valid_in = 1'b1; bus.alu_dest_in = d; bus.alu_data_in = v;
    #1;
    while (!bus.alu_ready_out && stalls < 100) begin
      tick(); #1; stalls++;
    end
    if (stalls >= 100) begin
      checks++; errors++;
      $display("FAIL alu_push_timeout dest=%0d never accepted", d);
    end
    tick();
    bus.alu_valid_in = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int n = 0;
    while (obs_dest.size() < target && n < budget) begin tick(); n++; end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    bus.alu_valid_in = 1'b0; bus.mem_valid_in = 1'b0; bus.pend_sel_in = 5'd0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.reg_wen_out !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b want 0", bus.reg_wen_out); end
    checks++; if (bus.reg_dest_out !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", bus.reg_dest_out); end
    checks++; if (bus.data_out !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.data_out); end
    checks++; if (bus.drop_cnt_out !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", bus.drop_cnt_out); end
    checks++; if (bus.idle_out !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b want 1", bus.idle_out); end
    checks++; if (bus.alu_ready_out !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %0b want 1", bus.alu_ready_out); end
    checks++; if (bus.mem_ready_out !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %0b want 1", bus.mem_ready_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int st;
    do_reset();
    alu_push(5'd3, 32'h0000_00AA, st);
    // after E0: queued, write port untouched
    checks++; if (bus.reg_wen_out !== 1'b0 || bus.reg_dest_out !== 5'd0) begin errors++; $display("FAIL single_e0 got wen=%0b dest=%0d want wen=0 dest=0", bus.reg_wen_out, bus.reg_dest_out); end
    checks++; if (bus.idle_out !== 1'b0) begin errors++; $display("FAIL single_e0_idle got %0b want 0", bus.idle_out); end
    tick(); // after E1: SETUP
    checks++; if (bus.reg_dest_out !== 5'd3 || bus.data_out !== 32'hAA || bus.reg_wen_out !== 1'b0) begin errors++; $display("FAIL single_setup got dest=%0d data=%h wen=%0b want 3 aa 0", bus.reg_dest_out, bus.data_out, bus.reg_wen_out); end
    tick(); // after E2: STROBE
    checks++; if (bus.reg_wen_out !== 1'b1 || bus.reg_dest_out !== 5'd3) begin errors++; $display("FAIL single_strobe got wen=%0b dest=%0d want 1 3", bus.reg_wen_out, bus.reg_dest_out); end
    tick(); // after E3: HOLD
    checks++; if (bus.reg_wen_out !== 1'b0 || bus.reg_dest_out !== 5'd3 || bus.idle_out !== 1'b0) begin errors++; $display("FAIL single_hold got wen=%0b dest=%0d idle=%0b want 0 3 0", bus.reg_wen_out, bus.reg_dest_out, bus.idle_out); end
    tick(); // after E4: IDLE
    checks++; if (bus.idle_out !== 1'b1 || bus.data_out !== 32'hAA) begin errors++; $display("FAIL single_idle got idle=%0b data=%h want 1 aa", bus.idle_out, bus.data_out); end
  endtask

  task automatic test_arbitration();
    int base;
    logic [31:0] d0, d1;
    do_reset();
    base = obs_dest.size();
    d0 = $urandom; d1 = $urandom;
    bus.alu_valid_in = 1'b1; bus.alu_dest_in = 5'd5; bus.alu_data_in = d0;
    bus.mem_valid_in = 1'b1; bus.mem_dest_in = 5'd6; bus.mem_data_in = d1;
    #1;
    checks++; if (bus.alu_ready_out !== 1'b1 || bus.mem_ready_out !== 1'b0) begin errors++; $display("FAIL arb_ready got alu=%0b mem=%0b want 1 0", bus.alu_ready_out, bus.mem_ready_out); end
    tick();
    bus.alu_valid_in = 1'b0;
    #1;
    checks++; if (bus.mem_ready_out !== 1'b1) begin errors++; $display("FAIL arb_mem_next got %0b want 1", bus.mem_ready_out); end
    tick();
    bus.mem_valid_in = 1'b0;
    wait_writes(base + 2, 30);
    checks++;
    if (obs_dest.size() != base + 2) begin
      errors++; $display("FAIL arb_count got %0d want 2", obs_dest.size() - base);
    end else begin
      checks++; if (obs_dest[base] !== 5'd5 || obs_data[base] !== d0) begin errors++; $display("FAIL arb_first got %0d/%h want 5/%h", obs_dest[base], obs_data[base], d0); end
      checks++; if (obs_dest[base+1] !== 5'd6 || obs_data[base+1] !== d1) begin errors++; $display("FAIL arb_second got %0d/%h want 6/%h", obs_dest[base+1], obs_data[base+1], d1); end
      checks++; if (obs_cyc[base+1] - obs_cyc[base] != 3) begin errors++; $display("FAIL arb_spacing got %0d want 3", obs_cyc[base+1] - obs_cyc[base]); end
    end
  endtask

  task automatic test_drop();
    logic [4:0]  dl[3];
    logic [31:0] vl[3];
    int base, st, exp_drop;
    do_reset();
    base = obs_dest.size();
    dl[0] = 5'd0; dl[1] = 5'd20; dl[2] = 5'd17;
    vl[0] = 32'h1111; vl[1] = 32'h2222; vl[2] = 32'h1000;
    exp_drop = 0;
    for (int k = 0; k < 3; k++) begin
      alu_push(dl[k], vl[k], st);
      if (dl[k] == 0 || dl[k] > 17) exp_drop++;
    end
    wait_writes(base + 1, 30);
    repeat (12) tick();
    checks++; if (bus.drop_cnt_out !== 8'(exp_drop)) begin errors++; $display("FAIL drop_cnt got %0d want %0d", bus.drop_cnt_out, exp_drop); end
    checks++;
    if (obs_dest.size() != base + 1) begin
      errors++; $display("FAIL drop_writes got %0d want 1", obs_dest.size() - base);
    end else begin
      checks++; if (obs_dest[base] !== 5'd17 || obs_data[base] !== 32'h1000) begin errors++; $display("FAIL drop_sp_write got %0d/%h want 17/1000", obs_dest[base], obs_data[base]); end
    end
  endtask

  task automatic test_drop_saturate();
    int st;
    do_reset();
    for (int k = 0; k < 260; k++) alu_push((k % 2 == 0) ? 5'd0 : 5'd31, 32'(k), st);
    tick();
    checks++; if (bus.drop_cnt_out !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d want 255", bus.drop_cnt_out); end
    checks++; if (bus.idle_out !== 1'b1) begin errors++; $display("FAIL drop_saturate_idle got %0b want 1", bus.idle_out); end
  endtask

  // Seven back-to-back requests against one write per 3 cycles: the FIFO
  // reaches 4 entries after the sixth acceptance, so the seventh waits two
  // cycles until the next pop.
  task automatic test_fill();
    logic [31:0] vals[7];
    int st[7];
    int base;
    do_reset();
    base = obs_dest.size();
    for (int k = 0; k < 7; k++) begin
      vals[k] = $urandom;
      alu_push(5'(k + 1), vals[k], st[k]);
    end
    for (int k = 0; k < 7; k++) begin
      checks++; if (st[k] != ((k == 6) ? 2 : 0)) begin errors++; $display("FAIL fill_stall req=%0d got %0d want %0d", k + 1, st[k], (k == 6) ? 2 : 0); end
    end
    wait_writes(base + 7, 60);
    checks++;
    if (obs_dest.size() != base + 7) begin
      errors++; $display("FAIL fill_count got %0d want 7", obs_dest.size() - base);
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++; if (obs_dest[base+k] !== 5'(k + 1) || obs_data[base+k] !== vals[k]) begin errors++; $display("FAIL fill_order idx=%0d got %0d/%h want %0d/%h", k, obs_dest[base+k], obs_data[base+k], k + 1, vals[k]); end
      end
    end
  endtask

  task automatic test_pending();
    logic [4:0] exp_seq;
    int st;
    do_reset();
    bus.pend_sel_in = 5'd7;
    #1;
    checks++; if (bus.pend_hit_out !== 1'b0) begin errors++; $display("FAIL pend_empty got %0b want 0", bus.pend_hit_out); end
    alu_push(5'd7, 32'h77, st);
    // queued, SETUP, STROBE, HOLD, IDLE
    exp_seq = 5'b00111;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.pend_hit_out !== exp_seq[k]) begin errors++; $display("FAIL pend_seq phase=%0d got %0b want %0b", k, bus.pend_hit_out, exp_seq[k]); end
      tick();
    end
    bus.pend_sel_in = 5'd8;
    alu_push(5'd7, 32'h78, st);
    #1;
    checks++; if (bus.pend_hit_out !== 1'b0) begin errors++; $display("FAIL pend_other got %0b want 0", bus.pend_hit_out); end
    repeat (6) tick();
    bus.pend_sel_in = 5'd0;
    alu_push(5'd3, 32'h33, st);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.pend_hit_out !== 1'b0) begin errors++; $display("FAIL pend_zero phase=%0d got %0b want 0", k, bus.pend_hit_out); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int st, base;
    do_reset();
    alu_push(5'd9, 32'h99, st);
    alu_push(5'd10, 32'hA0, st);
    alu_push(5'd11, 32'hB0, st);
    // after E2: strobing dest 9, two entries still queued
    checks++; if (bus.reg_wen_out !== 1'b1 || bus.reg_dest_out !== 5'd9) begin errors++; $display("FAIL mid_pre got wen=%0b dest=%0d want 1 9", bus.reg_wen_out, bus.reg_dest_out); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.reg_wen_out !== 1'b0) begin errors++; $display("FAIL mid_wen got %0b want 0", bus.reg_wen_out); end
    checks++; if (bus.reg_dest_out !== 5'd0 || bus.data_out !== 32'd0) begin errors++; $display("FAIL mid_outs got %0d/%h want 0/0", bus.reg_dest_out, bus.data_out); end
    tick(); tick();
    rst = 1'b0;
    base = obs_dest.size();
    repeat (12) tick();
    checks++; if (obs_dest.size() != base) begin errors++; $display("FAIL mid_no_strobe got %0d want 0", obs_dest.size() - base); end
    checks++; if (bus.idle_out !== 1'b1) begin errors++; $display("FAIL mid_idle got %0b want 1", bus.idle_out); end
  endtask

  task automatic test_random();
    logic [4:0]  exp_dest[$];
    logic [31:0] exp_data[$];
    int          exp_drop, base, n_done;
    logic        exp_hit, av, mv;
    logic [4:0]  ad, md, ps;
    logic [31:0] adat, mdat;
    do_reset();
    base = obs_dest.size();
    exp_drop = 0;
    wen_double = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      av = ($urandom_range(0, 9) < 6);
      mv = ($urandom_range(0, 9) < 6);
      ad = 5'($urandom_range(0, 21));
      md = 5'($urandom_range(0, 21));
      adat = $urandom; mdat = $urandom;
      if (exp_dest.size() > 0 && $urandom_range(0, 1) == 1)
        ps = exp_dest[$urandom_range(0, exp_dest.size() - 1)];
      else
        ps = 5'($urandom_range(0, 21));
      bus.alu_valid_in = av; bus.alu_dest_in = ad; bus.alu_data_in = adat;
      bus.mem_valid_in = mv; bus.mem_dest_in = md; bus.mem_data_in = mdat;
      bus.pend_sel_in  = ps;
      #1;
      // pending = accepted writes whose strobe has not finished yet
      n_done = obs_dest.size() - base;
      if (n_done > 0 && obs_cyc[obs_cyc.size() - 1] == cyc) n_done--;
      exp_hit = 1'b0;
      if (ps != 0)
        for (int k = n_done; k < exp_dest.size(); k++)
          if (exp_dest[k] == ps) exp_hit = 1'b1;
      checks++; if (bus.pend_hit_out !== exp_hit) begin errors++; $display("FAIL rnd_pend cyc=%0d sel=%0d got %0b want %0b", c, ps, bus.pend_hit_out, exp_hit); end
      checks++; if (bus.mem_ready_out !== (bus.alu_ready_out && !av)) begin errors++; $display("FAIL rnd_mem_ready cyc=%0d got %0b want %0b", c, bus.mem_ready_out, bus.alu_ready_out && !av); end
      if (av && bus.alu_ready_out) begin
        if (ad == 0 || ad > 17) exp_drop++;
        else begin exp_dest.push_back(ad); exp_data.push_back(adat); end
      end else if (mv && bus.mem_ready_out) begin
        if (md == 0 || md > 17) exp_drop++;
        else begin exp_dest.push_back(md); exp_data.push_back(mdat); end
      end
    end
    tick();
    bus.alu_valid_in = 1'b0; bus.mem_valid_in = 1'b0; bus.pend_sel_in = 5'd0;
    wait_writes(base + exp_dest.size(), 400);
    repeat (4) tick();
    checks++;
    if (obs_dest.size() != base + exp_dest.size()) begin
      errors++; $display("FAIL rnd_count got %0d want %0d", obs_dest.size() - base, exp_dest.size());
    end else begin
      for (int k = 0; k < exp_dest.size(); k++) begin
        checks++; if (obs_dest[base+k] !== exp_dest[k] || obs_data[base+k] !== exp_data[k]) begin errors++; $display("FAIL rnd_write idx=%0d got %0d/%h want %0d/%h", k, obs_dest[base+k], obs_data[base+k], exp_dest[k], exp_data[k]); end
        if (k > 0) begin
          checks++; if (obs_cyc[base+k] - obs_cyc[base+k-1] < 3) begin errors++; $display("FAIL rnd_spacing idx=%0d got %0d want >=3", k, obs_cyc[base+k] - obs_cyc[base+k-1]); end
        end
      end
    end
    checks++; if (bus.drop_cnt_out !== 8'(exp_drop)) begin errors++; $display("FAIL rnd_drop got %0d want %0d", bus.drop_cnt_out, exp_drop); end
    checks++; if (wen_double != 0) begin errors++; $display("FAIL rnd_wen_width got %0d long strobes want 0", wen_double); end
    checks++; if (bus.idle_out !== 1'b1) begin errors++; $display("FAIL rnd_idle got %0b want 1", bus.idle_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_drop();
    test_drop_saturate();
    test_fill();
    test_pending();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
